// File: rtl/spi_slave_responder_if.sv
// Word-side port bundle of the SPI responder:
// TX valid/ready handshake plus the pulsed RX/status outputs.
interface spi_slave_responder_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_abort;
  logic              tx_underrun;

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output rx_abort,
    output tx_underrun
  );

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  rx_abort,
    input  tx_underrun
  );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave, MSB first, oversampled in the clk domain.
// Exchanges frames through a TX valid/ready port and pulsed RX.
module spi_slave_responder #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = '0,
  parameter int                SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  spi_slave_responder_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_sy;
  logic [SYNC_STAGES-1:0] ss_sy;
  logic [SYNC_STAGES-1:0] mosi_sy;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_q, ss_q;
  logic rise, fall, sel;

  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              frame_done;
  logic              done_p;
  logic              load_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sy <= '0;
      ss_sy   <= '1;
      mosi_sy <= '0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk};
      ss_sy   <= {ss_sy[SYNC_STAGES-2:0], ss_n};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi};
      sclk_q  <= sclk_s;
      ss_q    <= ss_s;
    end
  end

  assign sclk_s = sclk_sy[SYNC_STAGES-1];
  assign ss_s   = ss_sy[SYNC_STAGES-1];
  assign mosi_s = mosi_sy[SYNC_STAGES-1];

  assign rise = sclk_s & ~sclk_q;
  assign fall = ~sclk_s & sclk_q;
  assign sel  = ~ss_s & ss_q;

  assign rx_next = {rx_shift, mosi_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // In SHIFT a high ss_n level ends the frame, so it wins over sclk
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sel) state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (ss_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_now        = 1'b0;
    busy            = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      LOAD: begin
        busy     = 1'b1;
        load_now = 1'b1;
      end
      SHIFT: begin
        busy     = 1'b1;
        load_now = ~ss_s & fall & frame_done;
      end
      default: busy = 1'b0;
    endcase
    bus.tx_ready    = load_now & bus.tx_valid;
    bus.tx_underrun = load_now & ~bus.tx_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift     <= '0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      frame_done   <= 1'b0;
      done_p       <= 1'b0;
      miso_oe      <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.rx_abort <= 1'b0;
    end else begin
      bus.rx_valid <= done_p;
      done_p       <= 1'b0;
      bus.rx_abort <= 1'b0;
      if (load_now) begin
        tx_shift   <= bus.tx_valid ? bus.tx_data : DEFAULT_WORD;
        frame_done <= 1'b0;
      end
      unique case (state)
        IDLE: miso_oe <= 1'b0;
        LOAD: begin
          bit_cnt <= '0;
          miso_oe <= 1'b1;
        end
        SHIFT: begin
          if (ss_s) begin
            miso_oe      <= 1'b0;
            bus.rx_abort <= (bit_cnt != '0);
            bit_cnt      <= '0;
            frame_done   <= 1'b0;
          end else begin
            if (rise) begin
              rx_shift <= rx_next[DATA_W-2:0];
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                bit_cnt     <= '0;
                bus.rx_data <= rx_next;
                done_p      <= 1'b1;
                frame_done  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (fall && !frame_done)
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        default: miso_oe <= 1'b0;
      endcase
    end
  end

  assign miso = miso_oe & tx_shift[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: bit-banged SPI master,
// queue scoreboard for RX words and MISO words, pulse counters.
module tb_spi_slave_responder;

  localparam int          DW  = 32;
  localparam logic [31:0] DEF = 32'hDEAD_BEEF;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sclk    = 1'b0;
  logic ss_n    = 1'b1;
  logic mosi    = 1'b0;
  logic miso;
  logic miso_oe;
  logic busy;

  spi_slave_responder_if #(.DATA_W(DW)) bus();

  spi_slave_responder #(
    .DATA_W      (DW),
    .DEFAULT_WORD(DEF),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sclk   (sclk),
    .ss_n   (ss_n),
    .mosi   (mosi),
    .miso   (miso),
    .miso_oe(miso_oe),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_rdy = 0;
  int n_unr = 0;
  int n_rv  = 0;
  int n_ab  = 0;
  int n_ovl = 0;

  logic [31:0] rx_seen[$];
  logic [31:0] rx_exp[$];
  logic [31:0] mi_exp[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.tx_ready)    n_rdy++;
      if (bus.tx_underrun) n_unr++;
      if (bus.rx_abort)    n_ab++;
      if (bus.rx_valid) begin
        n_rv++;
        rx_seen.push_back(bus.rx_data);
      end
      if ((32'(bus.tx_ready | bus.tx_underrun)
           + 32'(bus.rx_valid)
           + 32'(bus.rx_abort)) > 1)
        n_ovl++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bits(input  logic [31:0] mo,
                      input  int          n,
                      output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      mosi = mo[31-i];
      wait_n(4);
      mi   = {mi[30:0], miso};
      sclk = 1'b1;
      wait_n(4);
    end
  endtask

  task automatic deselect();
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_n(3);
    chk("desel_busy", 32'(busy), 32'd0);
    chk("desel_oe", 32'(miso_oe), 32'd0);
  endtask

  task automatic select_chk(input logic msb);
    ss_n = 1'b0;
    wait_n(3);
    chk("sel_busy", 32'(busy), 32'd1);
    chk("sel_oe_early", 32'(miso_oe), 32'd0);
    wait_n(1);
    chk("sel_oe", 32'(miso_oe), 32'd1);
    chk("sel_miso_msb", 32'(miso), 32'(msb));
  endtask

  task automatic rx_pop(input string tag);
    logic [31:0] e;
    e = rx_exp.pop_front();
    if (rx_seen.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      chk(tag, rx_seen.pop_front(), e);
    end
  endtask

  initial begin
    logic [31:0] mi;
    logic [31:0] mi2;
    int r0, u0, v0, a0;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    wait_n(3);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", bus.rx_data, 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    reset_n = 1'b1;
    wait_n(2);

    // Single frame with a supplied TX word
    bus.tx_data  = 32'hA5A5_0F0F;
    bus.tx_valid = 1'b1;
    rx_exp.push_back(32'h1234_5678);
    mi_exp.push_back(32'hA5A5_0F0F);
    r0 = n_rdy; u0 = n_unr; v0 = n_rv; a0 = n_ab;
    select_chk(1'b1);
    bus.tx_valid = 1'b0;
    bits(32'h1234_5678, 31, mi);
    sclk = 1'b0;
    mosi = 1'b0;
    wait_n(4);
    mi   = {mi[30:0], miso};
    sclk = 1'b1;
    wait_n(3);
    chk("rxv_lat_early", 32'(bus.rx_valid), 32'd0);
    wait_n(1);
    chk("rxv_lat", 32'(bus.rx_valid), 32'd1);
    wait_n(1);
    chk("rxv_width", 32'(bus.rx_valid), 32'd0);
    deselect();
    chk("single_miso", mi, mi_exp.pop_front());
    rx_pop("single_rx");
    chk("single_rdy", 32'(n_rdy - r0), 32'd1);
    chk("single_unr", 32'(n_unr - u0), 32'd0);
    chk("single_rv", 32'(n_rv - v0), 32'd1);
    chk("single_ab", 32'(n_ab - a0), 32'd0);

    // Reset in the middle of a frame
    bus.tx_data  = 32'h0BAD_F00D;
    bus.tx_valid = 1'b1;
    ss_n = 1'b0;
    wait_n(4);
    bus.tx_valid = 1'b0;
    bits(32'hFFFF_0000, 10, mi);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_miso", 32'(miso), 32'd0);
    chk("mid_rst_oe", 32'(miso_oe), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rx_data", bus.rx_data, 32'd0);
    ss_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_n(3);
    reset_n = 1'b1;
    wait_n(3);

    // Underrun: no TX word at frame load
    rx_exp.push_back(32'h0F0F_55AA);
    mi_exp.push_back(DEF);
    r0 = n_rdy; u0 = n_unr; v0 = n_rv;
    select_chk(1'b1);
    bits(32'h0F0F_55AA, 32, mi);
    deselect();
    chk("unr_miso", mi, mi_exp.pop_front());
    rx_pop("unr_rx");
    chk("unr_rdy", 32'(n_rdy - r0), 32'd0);
    chk("unr_unr", 32'(n_unr - u0), 32'd1);
    chk("unr_rv", 32'(n_rv - v0), 32'd1);

    // Back-to-back frames under one select
    bus.tx_data  = 32'h1111_1111;
    bus.tx_valid = 1'b1;
    rx_exp.push_back(32'hCAFE_0001);
    rx_exp.push_back(32'hCAFE_0002);
    mi_exp.push_back(32'h1111_1111);
    mi_exp.push_back(32'h2222_2222);
    r0 = n_rdy; u0 = n_unr; v0 = n_rv;
    select_chk(1'b0);
    bus.tx_data = 32'h2222_2222;
    bits(32'hCAFE_0001, 32, mi);
    bits(32'hCAFE_0002, 32, mi2);
    deselect();
    bus.tx_valid = 1'b0;
    chk("b2b_miso0", mi, mi_exp.pop_front());
    chk("b2b_miso1", mi2, mi_exp.pop_front());
    rx_pop("b2b_rx0");
    rx_pop("b2b_rx1");
    chk("b2b_rdy", 32'(n_rdy - r0), 32'd2);
    chk("b2b_unr", 32'(n_unr - u0), 32'd0);
    chk("b2b_rv", 32'(n_rv - v0), 32'd2);

    // Abort after 17 bits
    r0 = n_rdy; u0 = n_unr; v0 = n_rv; a0 = n_ab;
    select_chk(1'b1);
    bits(32'hFFFF_FFFF, 17, mi);
    deselect();
    wait_n(2);
    chk("ab_rx_data", bus.rx_data, 32'hCAFE_0002);
    chk("ab_ab", 32'(n_ab - a0), 32'd1);
    chk("ab_rv", 32'(n_rv - v0), 32'd0);
    chk("ab_unr", 32'(n_unr - u0), 32'd1);
    chk("ab_rdy", 32'(n_rdy - r0), 32'd0);

    wait_n(4);
    chk("pulse_overlap", 32'(n_ovl), 32'd0);
    chk("rx_extra", 32'(rx_seen.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
